ctrl_decode_pipe: RTL and testbench

Registered, handshaked instruction-decode stage for the pipelined RV32I core; successor to the single-cycle combinational control unit. Accepts a fetched instruction and PC, decodes it into a control bundle held in an ID/EX output register, and detects load-use hazards, inserting one bubble when one occurs. Decoding of the M extension is optional. A saturating counter records illegal instructions. Branch resolution moves downstream: this block emits the branch type, not `pc_sel`.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/ctrl_decode_pipe_if.sv | 46 ++++
 rtl/ctrl_decode_comb.sv | 139 +++++++++++++
 rtl/ctrl_decode_pipe.sv | 89 ++++++++
 tb/tb_ctrl_decode_pipe.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the RV32I decode stage
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLT    = 5'd2,  ALU_SLTU  = 5'd3,
        ALU_XOR    = 5'd4,  ALU_OR   = 5'd5,  ALU_AND    = 5'd6,  ALU_SLL   = 5'd7,
        ALU_SRL    = 5'd8,  ALU_SRA  = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV   = 5'd14, ALU_DIVU  = 5'd15,
        ALU_REM    = 5'd16, ALU_REMU = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {WB_PC4 = 2'd0, WB_ALU = 2'd1, WB_LSU = 2'd2} wb_sel_e;
    typedef enum logic [1:0] {OPA_PC = 2'd0, OPA_RS1 = 2'd1, OPA_ZERO = 2'd2} opa_sel_e;

    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        alu_op_e    alu_op;
        opa_sel_e   opa_sel;
        logic       opb_sel;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] br_type;
        logic       rd_wren;
        logic       mem_wren;
        logic       mem_rden;
        logic       mem_us;
        logic [3:0] mem_wrnum;
        wb_sel_e    wb_sel;
        logic       insn_vld;
    } ctrl_bundle_t;

    // Byte-enable style size mask from funct3[1:0]
    function automatic logic [3:0] mem_size(input logic [1:0] sz);
        case (sz)
            2'b00:   mem_size = 4'b0001;
            2'b01:   mem_size = 4'b0011;
            default: mem_size = 4'b1111;
        endcase
    endfunction

    // alt selects sub/sra; caller only sets it where funct7 bit 30 is meaningful
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  f3_to_alu = ALU_SLL;
            3'b010:  f3_to_alu = ALU_SLT;
            3'b011:  f3_to_alu = ALU_SLTU;
            3'b100:  f3_to_alu = ALU_XOR;
            3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_to_alu = ALU_OR;
            default: f3_to_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// rtl/ctrl_decode_pipe_if.sv - fetch-side and execute-side signals of the decode stage
interface ctrl_decode_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [4:0]       alu_op;
    logic [1:0]       opa_sel;
    logic             opb_sel;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       br_type;
    logic             rd_wren;
    logic             mem_wren;
    logic             mem_rden;
    logic             mem_us;
    logic [3:0]       mem_wrnum;
    logic [1:0]       wb_sel;
    logic             insn_vld;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, alu_op,
               opa_sel, opb_sel, is_branch, is_jal, is_jalr, br_type, rd_wren,
               mem_wren, mem_rden, mem_us, mem_wrnum, wb_sel, insn_vld, illegal_cnt
    );

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, rs1_addr, rs2_addr, rd_addr, alu_op,
               opa_sel, opb_sel, is_branch, is_jal, is_jalr, br_type, rd_wren,
               mem_wren, mem_rden, mem_us, mem_wrnum, wb_sel, insn_vld, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode_comb.sv
// rtl/ctrl_decode_comb.sv - combinational RV32I(+M) instruction to control bundle decoder
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o,
    output logic         uses_rs1_o,
    output logic         uses_rs2_o
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       legal;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        bundle_o          = '0;
        bundle_o.rs1_addr = instr_i[19:15];
        bundle_o.rs2_addr = instr_i[24:20];
        bundle_o.rd_addr  = instr_i[11:7];
        bundle_o.alu_op   = ALU_ADD;
        bundle_o.opa_sel  = OPA_RS1;
        bundle_o.wb_sel   = WB_ALU;
        legal             = 1'b0;
        uses_rs1_o        = 1'b0;
        uses_rs2_o        = 1'b0;

        case (opcode)
            OPC_LUI: begin
                legal            = 1'b1;
                bundle_o.opa_sel = OPA_ZERO;
                bundle_o.opb_sel = 1'b1;
                bundle_o.rd_wren = 1'b1;
            end
            OPC_AUIPC: begin
                legal            = 1'b1;
                bundle_o.opa_sel = OPA_PC;
                bundle_o.opb_sel = 1'b1;
                bundle_o.rd_wren = 1'b1;
            end
            OPC_JAL: begin
                legal            = 1'b1;
                bundle_o.opa_sel = OPA_PC;
                bundle_o.opb_sel = 1'b1;
                bundle_o.wb_sel  = WB_PC4;
                bundle_o.is_jal  = 1'b1;
                bundle_o.rd_wren = 1'b1;
            end
            OPC_JALR: begin
                legal            = 1'b1;
                uses_rs1_o       = 1'b1;
                bundle_o.opb_sel = 1'b1;
                bundle_o.wb_sel  = WB_PC4;
                bundle_o.is_jalr = 1'b1;
                bundle_o.rd_wren = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1_o         = 1'b1;
                uses_rs2_o         = 1'b1;
                bundle_o.opa_sel   = OPA_PC;
                bundle_o.opb_sel   = 1'b1;
                bundle_o.is_branch = 1'b1;
                bundle_o.br_type   = funct3;
                case (funct3)
                    F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: legal = 1'b1;
                    default:                                          legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                uses_rs1_o         = 1'b1;
                bundle_o.opb_sel   = 1'b1;
                bundle_o.mem_rden  = 1'b1;
                bundle_o.wb_sel    = WB_LSU;
                bundle_o.rd_wren   = 1'b1;
                bundle_o.mem_us    = funct3[2];
                bundle_o.mem_wrnum = mem_size(funct3[1:0]);
                case (funct3)
                    F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                    default:                             legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                uses_rs1_o         = 1'b1;
                uses_rs2_o         = 1'b1;
                bundle_o.opb_sel   = 1'b1;
                bundle_o.mem_wren  = 1'b1;
                bundle_o.mem_wrnum = mem_size(funct3[1:0]);
                case (funct3)
                    F3_SB, F3_SH, F3_SW: legal = 1'b1;
                    default:             legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1_o       = 1'b1;
                bundle_o.opb_sel = 1'b1;
                bundle_o.rd_wren = 1'b1;
                bundle_o.alu_op  = f3_to_alu(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                uses_rs1_o       = 1'b1;
                uses_rs2_o       = 1'b1;
                bundle_o.rd_wren = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal           = 1'b1;
                    bundle_o.alu_op = f3_to_alu(funct3, 1'b0);
                end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
                    legal           = 1'b1;
                    bundle_o.alu_op = f3_to_alu(funct3, 1'b1);
                end else if ((funct7 == F7_MULDIV) && EN_M) begin
                    legal           = 1'b1;
                    bundle_o.alu_op = alu_op_e'(5'd10 + {2'b00, funct3});
                end
            end
            default: legal = 1'b0;
        endcase

        bundle_o.insn_vld = legal;
        // Illegal instructions still flow downstream but must have no side effects
        if (!legal) begin
            bundle_o.rd_wren   = 1'b0;
            bundle_o.mem_wren  = 1'b0;
            bundle_o.mem_rden  = 1'b0;
            bundle_o.is_branch = 1'b0;
            bundle_o.is_jal    = 1'b0;
            bundle_o.is_jalr   = 1'b0;
        end
    end
endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - registered decode stage with load-use stall and illegal counter
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit EN_M  = 1'b1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    ctrl_decode_pipe_if.slave bus
);
    ctrl_bundle_t     dec;
    ctrl_bundle_t     bundle_q, bundle_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             uses_rs1, uses_rs2;
    logic             rd_hit, stall, in_ready, accept;

    ctrl_decode_comb #(.EN_M(EN_M)) u_dec (
        .instr_i    (bus.instr),
        .bundle_o   (dec),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    // Held load's result is not yet available to the instruction being presented
    assign rd_hit = (uses_rs1 && (dec.rs1_addr == bundle_q.rd_addr)) ||
                    (uses_rs2 && (dec.rs2_addr == bundle_q.rd_addr));
    assign stall  = out_valid_q && bundle_q.mem_rden && (bundle_q.rd_addr != 5'd0) && rd_hit;

    assign in_ready = !bus.flush && !stall && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        bundle_d    = bundle_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            bundle_d    = dec;
            pc_d        = bus.pc;
            out_valid_d = 1'b1;
            if (!dec.insn_vld && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            pc_q        <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            bundle_q    <= bundle_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = pc_q;
    assign bus.rs1_addr    = bundle_q.rs1_addr;
    assign bus.rs2_addr    = bundle_q.rs2_addr;
    assign bus.rd_addr     = bundle_q.rd_addr;
    assign bus.alu_op      = bundle_q.alu_op;
    assign bus.opa_sel     = bundle_q.opa_sel;
    assign bus.opb_sel     = bundle_q.opb_sel;
    assign bus.is_branch   = bundle_q.is_branch;
    assign bus.is_jal      = bundle_q.is_jal;
    assign bus.is_jalr     = bundle_q.is_jalr;
    assign bus.br_type     = bundle_q.br_type;
    assign bus.rd_wren     = bundle_q.rd_wren;
    assign bus.mem_wren    = bundle_q.mem_wren;
    assign bus.mem_rden    = bundle_q.mem_rden;
    assign bus.mem_us      = bundle_q.mem_us;
    assign bus.mem_wrnum   = bundle_q.mem_wrnum;
    assign bus.wb_sel      = bundle_q.wb_sel;
    assign bus.insn_vld    = bundle_q.insn_vld;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb/tb_ctrl_decode_pipe.sv - directed checks of ctrl_decode_pipe with and without the M extension
module tb_ctrl_decode_pipe;

    typedef struct packed {
        logic [4:0] alu;
        logic [1:0] opa;
        logic       opb;
        logic [1:0] wb;
        logic       rdw;
        logic       rden;
        logic       wren;
        logic       us;
        logic [3:0] num;
        logic       br;
        logic       jal;
        logic       jalr;
        logic [2:0] brt;
        logic       vld;
        logic [4:0] rd;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        dec_t        exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[20];

    ctrl_decode_pipe_if #(.XLEN(32), .CNT_W(8)) bus_m ();
    ctrl_decode_pipe_if #(.XLEN(32), .CNT_W(2)) bus_n ();

    ctrl_decode_pipe #(.XLEN(32), .EN_M(1'b1), .CNT_W(8)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    ctrl_decode_pipe #(.XLEN(32), .EN_M(1'b0), .CNT_W(2)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

    always #5 clk = ~clk;

    function automatic dec_t mk(input int alu, input int opa, input int opb, input int wb,
                                input int rdw, input int rden, input int wren, input int us,
                                input int num, input int br, input int jal, input int jalr,
                                input int brt, input int vld, input int rd);
        dec_t d;
        d.alu  = 5'(alu);  d.opa = 2'(opa);  d.opb = 1'(opb);   d.wb   = 2'(wb);
        d.rdw  = 1'(rdw);  d.rden = 1'(rden); d.wren = 1'(wren); d.us  = 1'(us);
        d.num  = 4'(num);  d.br  = 1'(br);   d.jal = 1'(jal);   d.jalr = 1'(jalr);
        d.brt  = 3'(brt);  d.vld = 1'(vld);  d.rd  = 5'(rd);
        return d;
    endfunction

    function automatic dec_t act_m();
        return {bus_m.alu_op, bus_m.opa_sel, bus_m.opb_sel, bus_m.wb_sel, bus_m.rd_wren,
                bus_m.mem_rden, bus_m.mem_wren, bus_m.mem_us, bus_m.mem_wrnum, bus_m.is_branch,
                bus_m.is_jal, bus_m.is_jalr, bus_m.br_type, bus_m.insn_vld, bus_m.rd_addr};
    endfunction

    function automatic dec_t act_n();
        return {bus_n.alu_op, bus_n.opa_sel, bus_n.opb_sel, bus_n.wb_sel, bus_n.rd_wren,
                bus_n.mem_rden, bus_n.mem_wren, bus_n.mem_us, bus_n.mem_wrnum, bus_n.is_branch,
                bus_n.is_jal, bus_n.is_jalr, bus_n.br_type, bus_n.insn_vld, bus_n.rd_addr};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic fl, input logic rdy);
        bus_m.in_valid = v; bus_m.instr = ins; bus_m.pc = p; bus_m.flush = fl; bus_m.out_ready = rdy;
        bus_n.in_valid = v; bus_n.instr = ins; bus_n.pc = p; bus_n.flush = fl; bus_n.out_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready(input string nm, input logic exp);
        @(negedge clk);
        chk(nm, 64'({bus_m.in_ready, bus_n.in_ready}), 64'({exp, exp}));
    endtask

    initial begin
        //                       alu opa opb wb rdw rden wren us num br jal jalr brt vld rd
        vecs[0]  = '{32'h002081B3, mk(0, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3)};
        vecs[1]  = '{32'h402081B3, mk(1, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3)};
        vecs[2]  = '{32'h4020D233, mk(9, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 4)};
        vecs[3]  = '{32'h0020B2B3, mk(3, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 5)};
        vecs[4]  = '{32'h4020C1B3, mk(0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 3)};
        vecs[5]  = '{32'hFFF08313, mk(0, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 6)};
        vecs[6]  = '{32'h4030D393, mk(9, 1, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 7)};
        vecs[7]  = '{32'h40309393, mk(7, 1, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 7)};
        vecs[8]  = '{32'h12345437, mk(0, 2, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 8)};
        vecs[9]  = '{32'h00001497, mk(0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 9)};
        vecs[10] = '{32'h008000EF, mk(0, 0, 1, 0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 1, 1)};
        vecs[11] = '{32'h00008067, mk(0, 1, 1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0)};
        vecs[12] = '{32'h00209463, mk(0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 1, 1, 8)};
        vecs[13] = '{32'h0020A463, mk(0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 8)};
        vecs[14] = '{32'h0040A383, mk(0, 1, 1, 2, 1, 1, 0, 0, 15, 0, 0, 0, 0, 1, 7)};
        vecs[15] = '{32'h0000C383, mk(0, 1, 1, 2, 1, 1, 0, 1, 1,  0, 0, 0, 0, 1, 7)};
        vecs[16] = '{32'h00209323, mk(0, 1, 1, 1, 0, 0, 1, 0, 3,  0, 0, 0, 0, 1, 6)};
        vecs[17] = '{32'h0000B383, mk(0, 1, 1, 2, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 7)};
        vecs[18] = '{32'h0020B023, mk(0, 1, 1, 1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0)};
        vecs[19] = '{32'h0000007F, mk(0, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0)};

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        rst_n = 1'b0;
        step(); step();
        chk("reset_state", 64'({bus_m.out_valid, bus_m.out_pc, bus_m.illegal_cnt, bus_n.illegal_cnt}), 64'(0));
        chk("reset_bundle", 64'({act_m(), act_n()}), 64'(0));
        rst_n = 1'b1;
        step();

        // M extension: decoded by dut_m, illegal and counted by dut_n
        drive(1'b1, 32'h022081B3, 32'h40, 1'b0, 1'b1);
        step();
        chk("mul_m", 64'({bus_m.out_valid, bus_m.alu_op, bus_m.insn_vld, bus_m.rd_wren, bus_m.illegal_cnt}),
            64'({1'b1, 5'd10, 1'b1, 1'b1, 8'd0}));
        chk("mul_n", 64'({bus_n.out_valid, bus_n.insn_vld, bus_n.rd_wren, bus_n.illegal_cnt}),
            64'({1'b1, 1'b0, 1'b0, 2'd1}));
        drive(1'b1, 32'h0220E1B3, 32'h44, 1'b0, 1'b1);
        step();
        chk("rem_m", 64'({bus_m.alu_op, bus_m.insn_vld}), 64'({5'd16, 1'b1}));
        chk("rem_n", 64'({bus_n.insn_vld, bus_n.illegal_cnt}), 64'({1'b0, 2'd2}));

        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vecs[i].instr, 32'(32'h100 + 4 * i), 1'b0, 1'b1);
            chk_ready($sformatf("vec%0d_ready", i), 1'b1);
            step();
            chk($sformatf("vec%0d_m", i), 64'(act_m()), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_n", i), 64'(act_n()), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_pc", i), 64'({bus_m.out_valid, bus_m.out_pc}), 64'({1'b1, 32'(32'h100 + 4 * i)}));
        end
        chk("table_cnt", 64'({bus_m.illegal_cnt, bus_n.illegal_cnt}), 64'({8'd6, 2'd3}));

        // Load-use: lw x5 then add x6,x5,x2 costs one bubble
        drive(1'b1, 32'h0000A283, 32'h300, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h00228333, 32'h304, 1'b0, 1'b1);
        chk_ready("lu_stall", 1'b0);
        step();
        chk("lu_bubble", 64'({bus_m.out_valid, bus_n.out_valid}), 64'(0));
        chk_ready("lu_resume", 1'b1);
        step();
        chk("lu_issue", 64'({bus_m.out_valid, bus_m.rd_addr, bus_m.rs1_addr, bus_m.rs2_addr, bus_m.out_pc}),
            64'({1'b1, 5'd6, 5'd5, 5'd2, 32'h304}));

        // Load to x0 never stalls
        drive(1'b1, 32'h0000A003, 32'h308, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h00200333, 32'h30C, 1'b0, 1'b1);
        chk_ready("lu_x0_ready", 1'b1);
        step();
        chk("lu_x0_issue", 64'({bus_m.out_valid, bus_m.rd_addr, bus_m.out_pc}), 64'({1'b1, 5'd6, 32'h30C}));

        // Backpressure: bundle held for 3 cycles, then next accepted on release
        drive(1'b1, 32'h002081B3, 32'h200, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk_ready($sformatf("bp%0d_ready", c), 1'b0);
            step();
            chk($sformatf("bp%0d_hold", c), 64'({bus_m.out_valid, bus_m.alu_op, bus_m.out_pc}),
                64'({1'b1, 5'd0, 32'h200}));
        end
        drive(1'b1, 32'h402081B3, 32'h204, 1'b0, 1'b1);
        chk_ready("bp_release", 1'b1);
        step();
        chk("bp_next", 64'({bus_m.out_valid, bus_m.alu_op, bus_m.out_pc}), 64'({1'b1, 5'd1, 32'h204}));

        // Flush beats an offered illegal instruction; it is taken only when re-presented
        drive(1'b1, 32'h0000007F, 32'h208, 1'b1, 1'b0);
        chk_ready("flush_ready", 1'b0);
        step();
        chk("flush_kill", 64'({bus_m.out_valid, bus_n.out_valid, bus_m.illegal_cnt}), 64'({2'b00, 8'd6}));
        drive(1'b1, 32'h0000007F, 32'h208, 1'b0, 1'b1);
        step();
        chk("flush_retry", 64'({bus_m.out_valid, bus_m.out_pc, bus_m.illegal_cnt}), 64'({1'b1, 32'h208, 8'd7}));

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        chk("drain", 64'({bus_m.out_valid, bus_n.out_valid}), 64'(0));

        // Asynchronous reset while a bundle is held
        drive(1'b1, 32'h002081B3, 32'h20C, 1'b0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 64'({bus_m.out_valid, bus_m.out_pc, bus_m.illegal_cnt, bus_n.illegal_cnt}), 64'(0));
        chk("rst_mid_bundle", 64'({act_m(), bus_m.rs1_addr, bus_m.rs2_addr}), 64'(0));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // Counter saturation: 2-bit counter stops at 3, 8-bit keeps counting
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h0000007F, 32'h400, 1'b0, 1'b1);
            step();
            chk($sformatf("sat%0d", k), 64'({bus_m.insn_vld, bus_m.illegal_cnt, bus_n.illegal_cnt}),
                64'({1'b0, 8'(k), 2'((k > 3) ? 3 : k)}));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
